// File: rtl/toothless_pkg.sv
// rtl/toothless_pkg.sv - shared opcode types for the toothless execution units
package toothless_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_opcode_e;

    typedef enum logic [3:0] {
        MD_MUL    = 4'd0,
        MD_MULH   = 4'd1,
        MD_MULHSU = 4'd2,
        MD_MULHU  = 4'd3,
        MD_DIV    = 4'd4,
        MD_DIVU   = 4'd5,
        MD_REM    = 4'd6,
        MD_REMU   = 4'd7
    } md_opcode_e;

endpackage

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative radix-2 multiply/divide unit with valid/ready handshakes
module alu_muldiv
    import toothless_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  md_opcode_e            operator_i,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    input  logic                  kill_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int N  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;

    state_e         state_q, state_d;
    md_opcode_e     op_q;
    logic [N-1:0]   a_q, b_q, result_q;
    logic [2*N-1:0] acc_q;
    logic [N:0]     rem_q;
    logic [CW-1:0]  cnt_q;
    logic           neg_q;

    logic           is_mul, is_div, is_rem, a_signed, b_signed, sa, sb;
    logic           div_zero, div_ovf;
    logic [N-1:0]   abs_a, abs_b, special_res;
    logic [N:0]     mul_sum;
    logic [2*N-1:0] acc_step, prod_fix;
    logic [N+1:0]   trial;
    logic [N:0]     rem_step;
    logic [N-1:0]   quo_step, quo_fix, rem_fix, result_fix;

    always_comb begin
        is_mul   = 1'b0;
        is_div   = 1'b0;
        is_rem   = 1'b0;
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op_q)
            MD_MUL:    is_mul = 1'b1;
            MD_MULH:   begin is_mul = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
            MD_MULHSU: begin is_mul = 1'b1; a_signed = 1'b1; end
            MD_MULHU:  is_mul = 1'b1;
            MD_DIV:    begin is_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
            MD_DIVU:   is_div = 1'b1;
            MD_REM:    begin is_div = 1'b1; is_rem = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
            MD_REMU:   begin is_div = 1'b1; is_rem = 1'b1; end
            default:   ;
        endcase
    end

    always_comb begin
        sa       = a_signed & a_q[N-1];
        sb       = b_signed & b_q[N-1];
        abs_a    = sa ? -a_q : a_q;
        abs_b    = sb ? -b_q : b_q;
        div_zero = is_div && (b_q == '0);
        div_ovf  = is_div && b_signed && (a_q == {1'b1, {(N-1){1'b0}}}) && (b_q == '1);
        if (div_zero) special_res = is_rem ? a_q : '1;
        else          special_res = is_rem ? '0 : a_q;

        // Multiply: {hi, lo} where lo starts as |b| and is consumed LSB first.
        mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, a_q} : '0);
        acc_step = {mul_sum, acc_q[N-1:1]};

        // Divide: a_q shifts the dividend out and the quotient bits in.
        trial    = {rem_q, a_q[N-1]} - {2'b00, b_q};
        rem_step = trial[N+1] ? {rem_q[N-1:0], a_q[N-1]} : trial[N:0];
        quo_step = {a_q[N-2:0], ~trial[N+1]};

        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -a_q : a_q;
        rem_fix  = neg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
        case (op_q)
            MD_MUL:                       result_fix = prod_fix[N-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result_fix = prod_fix[2*N-1:N];
            MD_DIV, MD_DIVU:              result_fix = quo_fix;
            MD_REM, MD_REMU:              result_fix = rem_fix;
            default:                      result_fix = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i) state_d = PREP;
            PREP:    state_d = (div_zero || div_ovf) ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MD_MUL;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (valid_i) begin
                    op_q <= operator_i;
                    a_q  <= operand_a_i;
                    b_q  <= operand_b_i;
                end
                PREP: begin
                    a_q   <= abs_a;
                    b_q   <= abs_b;
                    acc_q <= {{N{1'b0}}, abs_b};
                    rem_q <= '0;
                    neg_q <= is_rem ? sa : (sa ^ sb);
                    cnt_q <= CW'(N-1);
                    if (div_zero || div_ovf) result_q <= special_res;
                end
                CALC: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                    if (is_mul) acc_q <= acc_step;
                    if (is_div) begin
                        rem_q <= rem_step;
                        a_q   <= quo_step;
                    end
                end
                FIX:     result_q <= result_fix;
                default: ;
            endcase
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - randomized self-checking bench for alu_muldiv against an arithmetic model
module tb_alu_muldiv;
    import toothless_pkg::*;

    logic        clk, rst_n, valid_i, ready_o, kill_i, valid_o, ready_i;
    md_opcode_e  operator_i;
    logic [31:0] operand_a_i, operand_b_i, result_o;

    int checks = 0;
    int failures = 0;

    alu_muldiv #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .operator_i(operator_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .kill_i(kill_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        int ai, bi;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        ai = $signed(a);
        bi = $signed(b);
        case (op)
            4'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            4'd1: begin p = sa * sb; return p[63:32]; end
            4'd2: begin p = sa * ub; return p[63:32]; end
            4'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            4'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ai / bi);
            end
            4'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ai % bi);
            end
            4'd7: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 4'd4 && op <= 4'd7 && b == 0) return 2;
        if ((op == 4'd4 || op == 4'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit with_kill);
        @(negedge clk);
        chk("ready_before", ready_o, 1);
        valid_i = 1'b1;
        operator_i = md_opcode_e'(op);
        operand_a_i = a;
        operand_b_i = b;
        kill_i = with_kill;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        kill_i = 1'b0;
        operand_a_i = $urandom;
        operand_b_i = $urandom;
        chk("accepted", ready_o, 0);
    endtask

    task automatic finish_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int rdly);
        int cyc;
        bit seen;
        logic [31:0] exp;
        exp = ref_res(op, a, b);
        cyc = 1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid_o) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            cyc++;
        end
        chk({tag, "_valid_seen"}, seen, 1);
        chk({tag, "_latency"}, cyc, ref_lat(op, a, b));
        chk({tag, "_result"}, result_o, exp);
        for (int i = 0; i < rdly; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, valid_o, 1);
            chk({tag, "_hold_result"}, result_o, exp);
        end
        chk({tag, "_no_accept_while_done"}, ready_o, 0);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        chk({tag, "_ready_after_consume"}, ready_o, 1);
        chk({tag, "_valid_after_consume"}, valid_o, 0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int rdly);
        start_op(op, a, b, 1'b0);
        finish_op(tag, op, a, b, rdly);
    endtask

    task automatic expect_quiet(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (valid_o) seen = 1;
        end
        chk(tag, seen, 0);
    endtask

    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        logic [3:0] op;
        logic [31:0] a, b;
        rst_n = 1'b0;
        valid_i = 1'b0;
        kill_i = 1'b0;
        ready_i = 1'b0;
        operator_i = MD_MUL;
        operand_a_i = '0;
        operand_b_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_result", result_o, 0);
        rst_n = 1'b1;

        run_op("mul_neg", 4'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op("mulhu_max", 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulh_m1", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu", 4'd2, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("div_neg", 4'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_neg", 4'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu", 4'd5, 32'd100, 32'd7, 0);
        run_op("remu", 4'd7, 32'd100, 32'd7, 0);
        run_op("divu_zero", 4'd5, 32'd5, 32'd0, 0);
        run_op("rem_zero", 4'd6, 32'd5, 32'd0, 0);
        run_op("div_ovf", 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("unknown_op", 4'hF, 32'd9, 32'd9, 0);
        run_op("backpressure", 4'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5);

        start_op(4'd0, 32'h0001_2345, 32'h0000_0777, 1'b0);
        repeat (11) @(posedge clk);
        @(negedge clk);
        kill_i = 1'b1;
        @(posedge clk);
        #1;
        kill_i = 1'b0;
        chk("kill_idle_ready", ready_o, 1);
        chk("kill_no_valid", valid_o, 0);
        expect_quiet("kill_quiet");
        run_op("after_kill", 4'd0, 32'd3, 32'd4, 0);

        start_op(4'd5, 32'd100, 32'd7, 1'b1);
        finish_op("kill_in_idle", 4'd5, 32'd100, 32'd7, 0);
        run_op("prime_result", 4'd0, 32'd3, 32'd4, 0);

        start_op(4'd0, 32'h0001_2345, 32'h0000_0777, 1'b0);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", ready_o, 1);
        chk("arst_valid", valid_o, 0);
        chk("arst_result", result_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("arst_quiet");
        run_op("after_reset", 4'd0, 32'd3, 32'd4, 0);

        for (int n = 0; n < 48; n++) begin
            op = ($urandom_range(0, 15) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op("rand", op, a, b, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
